// File: rtl/acc_drain_pkg.sv
// acc_drain shared types and helpers.
// Round/saturate math and FIFO sizing.
package acc_drain_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } rs_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // v carries a w-bit signed value in its low bits; 64-bit math
  // cannot overflow for w < 64.
  function automatic rs_t round_sat(
    input logic [63:0] v,
    input int          w,
    input int          ow,
    input int          sh
  );
    logic signed [63:0] x;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    rs_t                r;
    x = $signed(v << (64 - w)) >>> (64 - w);
    if (sh > 0) begin
      x = (x + (64'sd1 <<< (sh - 1))) >>> sh;
    end
    mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (ow - 1));
    r.sat = 1'b0;
    r.val = x;
    if (x > mx) begin
      r.sat = 1'b1;
      r.val = mx;
    end else if (x < mn) begin
      r.sat = 1'b1;
      r.val = mn;
    end
    return r;
  endfunction

endpackage

// File: rtl/acc_drain_fifo.sv
// Small synchronous FIFO for acc_drain results.
// Head word is zero while empty.
module acc_drain_fifo
  import acc_drain_pkg::*;
#(
  parameter  int DW    = 17,
  parameter  int DEPTH = 4,
  localparam int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [PW:0]   count
);

  localparam logic [PW-1:0] P1 = PW'(1);
  localparam logic [PW:0]   C1 = (PW + 1)'(1);
  localparam logic [PW:0]   CD = (PW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr;
  logic          rd;

  assign empty = (count == '0);
  assign full  = (count == CD);
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + P1;
      end
      if (rd) begin
        rd_ptr <= rd_ptr + P1;
      end
      unique case ({wr, rd})
        2'b10:   count <= count + C1;
        2'b01:   count <= count - C1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/acc_drain.sv
// Window sequencer and output stage behind a
// feedback accumulator; results drain via valid/ready.
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 8,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 Res_en,
  output logic                 Res_mode,
  input  logic [WIDTH-1:0]     Res_cascade,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int DW = OUT_WIDTH + 1;
  localparam logic [LEN_W-1:0] L1 = LEN_W'(1);

  state_e           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_in;
  logic             pending;
  logic             accept;
  logic             win_end;

  logic [PW:0]      f_cnt;
  logic [PW+1:0]    credit;
  logic             f_empty;
  logic             full_unused;
  logic             f_pop;
  logic [DW-1:0]    f_din;
  logic [DW-1:0]    f_dout;
  rs_t              rs;
  logic             rs_unused;

  // Pending capture holds a credit so the FIFO never overflows.
  assign credit   = {1'b0, f_cnt} + (PW + 2)'(pending);
  assign in_ready = credit < (PW + 2)'(FIFO_DEPTH);
  assign accept   = in_valid & in_ready;
  assign Res_en   = accept;
  assign Res_mode = (state == ACCUM);
  assign busy     = (state == ACCUM) | pending;
  assign len_in   = (cfg_len == '0) ? L1 : cfg_len;

  always_comb begin
    win_end = 1'b0;
    unique case (1'b1)
      (state == IDLE):  win_end = accept && (len_in == L1);
      (state == ACCUM): win_end = accept && (cnt == len_q - L1);
      default:          win_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      pending <= win_end;
      if (accept) begin
        unique case (1'b1)
          (state == IDLE): begin
            len_q <= len_in;
            cnt   <= L1;
            if (!win_end) begin
              state <= ACCUM;
            end
          end
          (state == ACCUM): begin
            cnt <= cnt + L1;
            if (win_end) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Res_cascade holds the final sum during the pending cycle.
  assign rs        = round_sat(64'(Res_cascade), WIDTH, OUT_WIDTH, SHIFT);
  assign rs_unused = ^rs.val[63:OUT_WIDTH];
  assign f_din     = {rs.sat, rs.val[OUT_WIDTH-1:0]};
  assign f_pop     = ~f_empty & out_ready;

  acc_drain_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pending),
    .din   (f_din),
    .pop   (f_pop),
    .dout  (f_dout),
    .empty (f_empty),
    .full  (full_unused),
    .count (f_cnt)
  );

  assign out_valid = ~f_empty;
  assign out_sat   = f_dout[OUT_WIDTH];
  assign out_data  = f_dout[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain with a feedback
// accumulator model and an output scoreboard.
module tb_acc_drain;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [7:0]         cfg_len;
  logic               in_valid;
  logic               in_ready;
  logic               Res_en;
  logic               Res_mode;
  logic [31:0]        Res_cascade;
  logic [15:0]        out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  logic signed [31:0] mult;
  logic signed [31:0] acc;
  logic [16:0]        sb [$];
  logic [16:0]        exp_w;
  int                 total = 0;
  int                 bad = 0;
  int                 npop = 0;

  always #5 clk = ~clk;

  acc_drain dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_len     (cfg_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Res_en      (Res_en),
    .Res_mode    (Res_mode),
    .Res_cascade (Res_cascade),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  // feedback accumulator, Res_in tied to 0
  always @(posedge clk or negedge reset) begin
    if (!reset) acc <= 32'sd0;
    else if (Res_en) acc <= (Res_mode ? acc : 32'sd0) + mult;
  end
  assign Res_cascade = acc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] ex);
    total++;
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, ex);
    end
  endtask

  function automatic logic [16:0] exp_of(input longint sum);
    longint r;
    r = sum + 128;
    if (r < 0) r = -((-r + 255) / 256);
    else r = r / 256;
    if (r > 32767) return {1'b1, 16'h7fff};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_w = sb.pop_front();
        chk("out_word", {15'd0, out_sat, out_data}, {15'd0, exp_w});
      end
      npop++;
    end
  end

  logic lmode;
  logic lbusy;
  bit   lok;

  task automatic send(input int s, input int maxc, output bit ok,
                      output logic mode, output logic bsy);
    ok = 0;
    mode = 1'bx;
    bsy = 1'bx;
    in_valid = 1'b1;
    mult = s;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        mode = Res_mode;
        bsy = busy;
        chk("res_en", 32'(Res_en), 32'd1);
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic tsend(input int s);
    send(s, 20, lok, lmode, lbusy);
    chk("accept_to", 32'(lok), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_n;
    int p0;
    longint sum;
    in_valid = 1'b0;
    mult = 0;
    cfg_len = 8'd0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res_en", 32'(Res_en), 32'd0);
    chk("rst_res_mode", 32'(Res_mode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", {15'd0, out_sat, out_data}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // basic window
    cfg_len = 8'd4;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      tsend(256 * (i + 1));
      sum += 256 * (i + 1);
      chk("mode_pat", 32'(lmode), (i == 0) ? 32'd0 : 32'd1);
    end
    sb.push_back(exp_of(sum));
    @(negedge clk);
    chk("lat_t1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_t2", 32'(out_valid), 32'd1);
    drain();

    // rounding
    cfg_len = 8'd1;
    tsend(384);
    sb.push_back(exp_of(384));
    tsend(-384);
    sb.push_back(exp_of(-384));
    tsend(127);
    sb.push_back(exp_of(127));
    drain();

    // saturation
    cfg_len = 8'd2;
    tsend(32'h0080_0000);
    tsend(32'h0080_0000);
    sb.push_back(exp_of(64'sh0100_0000));
    tsend(-32'sh0080_0000);
    tsend(-32'sh0080_0000);
    sb.push_back(exp_of(-64'sh0100_0000));
    drain();

    // back-pressure
    out_ready = 1'b0;
    cfg_len = 8'd1;
    acc_n = 0;
    for (int k = 0; k < 6; k++) begin
      send(256 * (k + 1), 6, lok, lmode, lbusy);
      if (lok) begin
        acc_n++;
        sb.push_back(exp_of(256 * (k + 1)));
        if (acc_n == 4) chk("credit_block", 32'(in_ready), 32'd0);
      end
    end
    chk("bp_accepted", acc_n, 4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    p0 = npop;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && npop < p0 + 4; i++) @(negedge clk);
    chk("bp_pops", npop - p0, 4);
    @(posedge clk);
    #1;
    for (int k = 4; k < 6; k++) begin
      tsend(256 * (k + 1));
      sb.push_back(exp_of(256 * (k + 1)));
    end
    drain();

    // back-to-back windows
    cfg_len = 8'd3;
    for (int i = 0; i < 3; i++) tsend(256);
    sb.push_back(exp_of(768));
    tsend(512);
    chk("b2b_mode", 32'(lmode), 32'd0);
    chk("b2b_busy", 32'(lbusy), 32'd1);
    tsend(512);
    tsend(512);
    sb.push_back(exp_of(1536));
    drain();

    // reset mid-operation
    out_ready = 1'b0;
    cfg_len = 8'd1;
    tsend(256);
    cfg_len = 8'd4;
    tsend(1000);
    tsend(1000);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cfg_len = 8'd1;
    tsend(512);
    sb.push_back(exp_of(512));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_drain.md
Name: acc_drain

Overview:
- Controller and output stage placed directly downstream of a FEEDBACK-type accumulator_v2 with DEPTH=1.
- Sequences the accumulator across one dot-product window: drives Res_en and Res_mode, and counts accepted mult_results.
- When a window ends, captures Res_cascade, rounds, shifts and saturates it to OUT_WIDTH, and queues the word in a small FIFO.
- The FIFO drains over a valid/ready interface to the next layer.

Parameters:
- WIDTH, 32: accumulator width; must match accumulator_v2 WIDTH.
- OUT_WIDTH, 16: signed output word width.
- SHIFT, 8: arithmetic right-shift applied with round-half-up. 0 means no shift and no rounding.
- LEN_W, 8: width of cfg_len.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- cfg_len  in  LEN_W  products per window. Sampled on the first accepted sample of each window. 0 is treated as 1.
- in_valid  in  1  mult_result is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- Res_en  out  1  accumulator enable; equals in_valid & in_ready.
- Res_mode  out  1  0 on the first sample of a window (accumulator loads Res_in, tied to 0 or bias), 1 otherwise (feedback).
- Res_cascade  in  WIDTH  accumulator result (signed).
- out_data  out  OUT_WIDTH  rounded, saturated result (signed).
- out_sat  out  1  out_data was saturated.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head entry.
- busy  out  1  a window is in progress, or a capture is pending.

Behaviour:
- Reset (async, active-low): FSM=IDLE, cnt=0, pending=0, FIFO empty. Outputs: out_valid=0, out_data=0, out_sat=0, in_ready=1, Res_en=0, Res_mode=0, busy=0.
- FSM has two states, IDLE and ACCUM.
  - IDLE: Res_mode=0. On an accepted sample: len_q <= max(cfg_len,1), cnt <= 1.
    - If len_q==1, the window ends immediately and the FSM stays in IDLE.
    - Otherwise the FSM goes to ACCUM.
  - ACCUM: Res_mode=1. Each accepted sample does cnt++. The sample with cnt==len_q-1 ends the window and the FSM returns to IDLE.
- Window end: on the cycle the last sample is accepted (cycle t), set pending <= 1.
  - In cycle t+1, Res_cascade holds the final sum.
  - At the end of t+1 the block writes the processed value into the FIFO and clears pending.
- A new window may accept its first sample in cycle t+1. The capture reads the pre-edge accumulator value, so back-to-back windows lose no cycle.
- Credit rule: in_ready = (FIFO count + pending) < FIFO_DEPTH. The rule applies every cycle, including mid-window, so a capture never overflows the FIFO.
- Arithmetic:
  - r = (sext(Res_cascade, WIDTH+1) + 2^(SHIFT-1)) >>> SHIFT, computed in WIDTH+1 bits.
  - If r > 2^(OUT_WIDTH-1)-1, clamp to the maximum and set sat=1.
  - If r < -2^(OUT_WIDTH-1), clamp to the minimum and set sat=1.
  - Accumulator overflow (wrap inside accumulator_v2) is not detected.
- FIFO:
  - out_data/out_sat show the head entry; out_valid=~empty.
  - Pop when out_valid & out_ready.
  - A simultaneous push and pop on a full FIFO is legal: count is unchanged, credit is freed next cycle.
  - Push into an empty FIFO: out_valid rises the following cycle (registered FIFO, 1-cycle write-to-read).
- Latency: last sample accepted at t → out_valid at t+2 (empty FIFO, no back-pressure).
- cfg_len changes mid-window are ignored.
- busy = (state==ACCUM) | pending.
- Reset mid-window discards the partial count, pending capture and FIFO contents. The accumulator is reset externally on the same reset.

Decomposition:
- Package acc_drain_pkg holds: the state enum (IDLE, ACCUM); the round/saturate function parameterised by WIDTH, OUT_WIDTH and SHIFT; and the FIFO pointer-width localparam derivation.
- One sub-module, acc_drain_fifo: synchronous FIFO, async active-low reset, data width OUT_WIDTH+1, with push, pop, empty, full and count ports.

Test Plan:
- Basic window: cfg_len=4, samples 256, 512, 768, 1024 back-to-back, out_ready=1 → Res_mode pattern 0,1,1,1; out_data=10, out_sat=0; out_valid asserted 2 cycles after the 4th accept.
- Rounding: cfg_len=1 with sample 384 → out_data=2. cfg_len=1 with sample -384 → out_data=-1. cfg_len=1 with sample 127 → out_data=0.
- Saturation: cfg_len=2, samples 0x0080_0000 twice → out_data=32767, out_sat=1. cfg_len=2, samples -0x0080_0000 twice → out_data=-32768, out_sat=1.
- Back-pressure: out_ready=0, 6 windows offered with cfg_len=1 → exactly 4 accepted. in_ready=0 from the cycle after the 4th accept. Raise out_ready → 4 entries pop in order, then the remaining windows complete.
- Back-to-back: two cfg_len=3 windows with no gap, sums 3·256 and 3·512 → outputs 3 then 6. The first sample of window 2 is accepted in the capture cycle of window 1.
- Reset mid-operation: assert reset after 2 of 4 samples with 1 FIFO entry held → out_valid=0, busy=0, in_ready=1 immediately (async). The next window with cfg_len=1 and sample 512 → out_data=2.
